// File: rtl/cable_pkg.sv
// Purpose: request record carried between mem_ctrl and its in-order queue.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cable_pkg;

  import const_pkg::*;

  // One outstanding request; index is already reduced modulo the storage size.
  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [LINE_WIDTH-1:0]  index;
    logic [DLINE_WIDTH-1:0] data;
    logic                   write;
    logic [CNT_WIDTH-1:0]   countdown;
  } mem_req_t;

  // Line address of a physical address, folded onto a storage of 'lines' entries.
  function automatic logic [LINE_WIDTH-1:0] line_index(input logic [PA_WIDTH-1:0] addr,
                                                      input int lines);
    logic [LINE_WIDTH-1:0] line;
    line = addr[PA_WIDTH-1:DLINE_OFFSET];
    return line % LINE_WIDTH'(lines);
  endfunction

endpackage

// File: rtl/const_pkg.sv
// Purpose: global width constants shared by the memory-side blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package const_pkg;

  localparam int PA_WIDTH     = 32;                     // physical address bits
  localparam int DLINE_WIDTH  = 128;                    // cache line bits
  localparam int DLINE_OFFSET = $clog2(DLINE_WIDTH / 8); // byte offset within a line
  localparam int LINE_WIDTH   = PA_WIDTH - DLINE_OFFSET; // line address bits
  localparam int ID_WIDTH     = 2;                      // request tag bits
  localparam int N_IDS        = 2 ** ID_WIDTH;          // max outstanding requests
  localparam int CNT_WIDTH    = 8;                      // latency countdown bits (1..255)

endpackage

// File: rtl/mem_queue.sv
// Purpose: in-order circular buffer of N_IDS requests, each with its own latency countdown.
// Latency: push visible at head one cycle later; countdowns fall by 1 per cycle, saturating at 0.
// Backpressure: full/empty flags from registered occupancy; push when full / pop when empty ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset (empties the buffer)
//   push, push_req  enqueue one request at the tail
//   pop             drop the head entry
//   head_req        current head entry (valid only when !empty)
//   full, empty     occupancy flags
module mem_queue
  import const_pkg::*;
  import cable_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mem_req_t push_req,
  input  logic     pop,
  output mem_req_t head_req,
  output logic     full,
  output logic     empty
);

  localparam int DEPTH = N_IDS;
  localparam int CW    = ID_WIDTH + 1;

  mem_req_t            entries [DEPTH];
  logic [ID_WIDTH-1:0] wr_ptr;
  logic [ID_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]       count;
  logic                push_ok;
  logic                pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Every slot ticks down, occupied or not; a stale slot reaching 0 is harmless
      // because only slots between rd_ptr and wr_ptr are ever looked at.
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && wr_ptr == ID_WIDTH'(i)) begin
          entries[i] <= push_req;
        end else if (entries[i].countdown != '0) begin
          entries[i].countdown <= entries[i].countdown - CNT_WIDTH'(1);
        end
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + ID_WIDTH'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ID_WIDTH'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_req = entries[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Purpose: fixed-latency line memory behind a data cache, tagged requests, in-order responses.
// Latency: accept at edge T -> read response valid from T+MEM_LATENCY; writes retire at T+MEM_LATENCY+1.
// Backpressure: o_mem_ready drops when N_IDS requests are outstanding; a read response holds until i_mem_ack.
//
// Optional feature macro: MEM_CTRL_PERF_EN adds o_perf_reads / o_perf_writes / o_perf_stalls.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   i_mem_enable/addr/data/write  request from cache (accepted when i_mem_enable && o_mem_ready)
//   o_mem_ready               request can be accepted this cycle
//   o_mem_id_request          ID that the next accepted request receives
//   o_mem_enable/data/id_response  read response (data/id forced to 0 while not valid)
//   i_mem_ack                 cache consumed the current read response
module mem_ctrl
  import const_pkg::*;
  import cable_pkg::*;
#(
  parameter int MEM_LINES   = 1024,
  parameter int MEM_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_mem_enable,
  input  logic [PA_WIDTH-1:0]    i_mem_addr,
  input  logic [DLINE_WIDTH-1:0] i_mem_data,
  input  logic                   i_mem_write,
  input  logic                   i_mem_ack,
  output logic                   o_mem_ready,
  output logic [ID_WIDTH-1:0]    o_mem_id_request,
  output logic                   o_mem_enable,
  output logic [DLINE_WIDTH-1:0] o_mem_data,
  output logic [ID_WIDTH-1:0]    o_mem_id_response
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [31:0]            o_perf_reads,
  output logic [31:0]            o_perf_writes,
  output logic [31:0]            o_perf_stalls
`endif
);

  localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 255) begin : g_bad_latency
    $error("mem_ctrl: MEM_LATENCY must lie in 1..255");
  end

  // Storage is deliberately not reset: a reset drops traffic, not contents.
  logic [DLINE_WIDTH-1:0] storage [MEM_LINES];

  logic [ID_WIDTH-1:0] id_cnt;
  logic                accept;
  logic                q_full;
  logic                q_empty;
  logic                head_due;
  logic                wr_done;
  logic                pop;
  logic [IDX_W-1:0]    head_idx;
  mem_req_t            push_req;
  mem_req_t            head_req;

  // Ready comes only from registered occupancy, so a pop never frees a slot
  // for a request arriving in the same cycle.
  assign o_mem_ready      = !q_full;
  assign accept           = i_mem_enable && o_mem_ready;
  assign o_mem_id_request = id_cnt;

  always_comb begin
    push_req           = '0;
    push_req.id        = id_cnt;
    push_req.index     = line_index(i_mem_addr, MEM_LINES);
    push_req.data      = i_mem_data;
    push_req.write     = i_mem_write;
    push_req.countdown = CNT_WIDTH'(MEM_LATENCY);
  end

  // ID counter width is exactly log2(N_IDS), so it wraps N_IDS-1 -> 0 on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_cnt <= '0;
    end else if (accept) begin
      id_cnt <= id_cnt + ID_WIDTH'(1);
    end
  end

  mem_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_req (push_req),
    .pop      (pop),
    .head_req (head_req),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Only the head may complete, which keeps completion strictly in acceptance order.
  assign head_due = !q_empty && (head_req.countdown == '0);
  assign wr_done  = head_due && head_req.write;
  assign head_idx = IDX_W'(head_req.index);

  assign o_mem_enable      = head_due && !head_req.write;
  assign o_mem_data        = o_mem_enable ? storage[head_idx] : '0;
  assign o_mem_id_response = o_mem_enable ? head_req.id : '0;

  // A write retires silently; a read retires only when the cache acknowledges it.
  assign pop = wr_done || (o_mem_enable && i_mem_ack);

  always_ff @(posedge clk) begin
    if (wr_done) begin
      storage[head_idx] <= head_req.data;
    end
  end

`ifdef MEM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_perf_reads  <= '0;
      o_perf_writes <= '0;
      o_perf_stalls <= '0;
    end else begin
      if (accept && !i_mem_write) begin
        o_perf_reads <= o_perf_reads + 32'd1;
      end
      if (accept && i_mem_write) begin
        o_perf_writes <= o_perf_writes + 32'd1;
      end
      if (i_mem_enable && !o_mem_ready) begin
        o_perf_stalls <= o_perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter MEM_LINES, default 1024: number of DLINE_WIDTH-wide storage lines.
REQ-002 Parameter MEM_LATENCY, default 4: cycles from request acceptance to completion; legal range 1..255.
REQ-003 Parameter N_IDS, fixed at 2**ID_WIDTH: maximum outstanding requests.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_mem_enable  input  1  request valid from data cache.
REQ-007 i_mem_addr  input  PA_WIDTH  physical line address of request.
REQ-008 i_mem_data  input  DLINE_WIDTH  write line.
REQ-009 i_mem_write  input  1  1 = write, 0 = read.
REQ-010 i_mem_ack  input  1  cache consumed current read response.
REQ-011 o_mem_ready  output  1  request can be accepted this cycle.
REQ-012 o_mem_id_request  output  ID_WIDTH  ID assigned to the request accepted this cycle.
REQ-013 o_mem_enable  output  1  read response valid.
REQ-014 o_mem_data  output  DLINE_WIDTH  read response line.
REQ-015 o_mem_id_response  output  ID_WIDTH  ID of current response.

Function
REQ-016 Acceptance = i_mem_enable && o_mem_ready; o_mem_ready SHALL equal (outstanding count != N_IDS), from registered state only.
REQ-017 o_mem_id_request SHALL always show the next ID counter; ID counter increments by 1 per acceptance, wrapping N_IDS-1 -> 0.
REQ-018 Accepted requests SHALL enter an in-order queue holding {id, line index, data, write, countdown}; countdown loaded with MEM_LATENCY.
REQ-019 Every queued countdown SHALL decrement by 1 per cycle, saturating at 0.
REQ-020 Line index SHALL be i_mem_addr[PA_WIDTH-1 : DLINE_OFFSET] modulo MEM_LINES.
REQ-021 Head write with countdown 0 SHALL update storage and pop at that edge; no response generated.
REQ-022 Head read with countdown 0 SHALL drive o_mem_enable=1, o_mem_data=storage[index], o_mem_id_response=id; held stable until i_mem_ack.
REQ-023 i_mem_ack while o_mem_enable=1 SHALL pop head at that edge; i_mem_ack while o_mem_enable=0 SHALL be ignored.
REQ-024 Minimum read latency: acceptance edge T -> o_mem_enable high in cycle T+MEM_LATENCY.
REQ-025 Responses SHALL return strictly in acceptance order; a read behind a write to the same line SHALL return the written data.
REQ-026 Simultaneous pop and acceptance SHALL both take effect; outstanding count unchanged.
REQ-027 When full, ready SHALL stay 0 in the pop cycle; it rises the following cycle.
REQ-028 o_mem_data and o_mem_id_response SHALL be 0 when o_mem_enable=0.

Reset
REQ-029 rst low SHALL immediately clear queue, outstanding count and ID counter to 0; o_mem_ready=1, o_mem_enable=0, o_mem_id_request=0, o_mem_id_response=0, o_mem_data=0.
REQ-030 Reset mid-operation SHALL drop all in-flight requests without completing writes; storage contents are not reset.

Configuration
REQ-031 Macro MEM_CTRL_PERF_EN defined: add outputs o_perf_reads, o_perf_writes and o_perf_stalls (32 bits each) counting accepted reads, accepted writes and cycles with i_mem_enable && !o_mem_ready; counters wrap and clear on reset.
REQ-032 MEM_CTRL_PERF_EN undefined: the ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-033 mem_req_t (id, index, data, write, countdown) SHALL live in cable_pkg; DLINE_OFFSET = log2(DLINE_WIDTH/8) in const_pkg.
REQ-034 The in-order queue SHALL be sub-module mem_queue (circular buffer, N_IDS entries, push/pop/full/empty, per-entry countdown); storage array stays in mem_ctrl.

Verification
REQ-035 Write line A=0x…AA to addr 0x100 at T0, read 0x100 at T0+1, MEM_LATENCY=4 -> o_mem_enable at T0+5, data 0x…AA, id_response 1.
REQ-036 Issue N_IDS reads back-to-back, no ack -> o_mem_ready=0 after Nth, stall counter increments; ack one -> ready=1 next cycle.
REQ-037 Issue N_IDS+3 requests over time with prompt acks -> ID sequence 0..N_IDS-1, 0, 1, 2 with wrap; responses in order.
REQ-038 Hold i_mem_ack=0 for 10 cycles on response -> o_mem_enable, data, ID stable all 10 cycles; single pop on ack.
REQ-039 Assert rst low with 3 reads outstanding -> outputs reset immediately; no responses after release; next ID=0.
REQ-040 Full queue, pop and i_mem_enable in same cycle -> request not accepted; accepted next cycle with the next ID.
